// File: rtl/fsm_seq_monitor.sv
// Protocol monitor for the 4-phase one-hot sequencer: tracks lock, checks
// each phase transition, counts frames and emits one report per frame.
module fsm_seq_monitor #(
   parameter int unsigned CNT_WIDTH   = 8,
   parameter int unsigned STALL_LIMIT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic                 mode,
   input  logic [3:0]           vector,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0] long_count,
   output logic                 locked,
   output logic                 err_code,
   output logic                 err_seq,
   output logic                 stall,
   output logic                 rpt_valid,
   input  logic                 rpt_ready,
   output logic                 rpt_long,
   output logic                 rpt_overrun
);

   localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [SW-1:0]        STALL_MAX = SW'(STALL_LIMIT);

   typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [3:0]           prev_vec_q, prev_vec_d;
   logic                 run_q, run_d, mode_q, mode_d, saw_long_q, saw_long_d;
   logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, long_cnt_q, long_cnt_d;
   logic [SW-1:0]        stall_cnt_q, stall_cnt_d;
   logic                 err_code_q, err_code_d, err_seq_q, err_seq_d;
   logic                 locked_q, locked_d, stall_q, stall_d;
   logic                 rpt_valid_q, rpt_valid_d, rpt_long_q, rpt_long_d;
   logic                 rpt_ovr_q, rpt_ovr_d;
   logic                 legal, frame_done;
   logic [3:0]           exp_vec;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SYNC;
         prev_vec_q  <= 4'b0000;
         run_q       <= 1'b0;
         mode_q      <= 1'b0;
         saw_long_q  <= 1'b0;
         frame_cnt_q <= '0;
         long_cnt_q  <= '0;
         stall_cnt_q <= '0;
         err_code_q  <= 1'b0;
         err_seq_q   <= 1'b0;
         locked_q    <= 1'b0;
         stall_q     <= 1'b0;
         rpt_valid_q <= 1'b0;
         rpt_long_q  <= 1'b0;
         rpt_ovr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_vec_q  <= prev_vec_d;
         run_q       <= run_d;
         mode_q      <= mode_d;
         saw_long_q  <= saw_long_d;
         frame_cnt_q <= frame_cnt_d;
         long_cnt_q  <= long_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_code_q  <= err_code_d;
         err_seq_q   <= err_seq_d;
         locked_q    <= locked_d;
         stall_q     <= stall_d;
         rpt_valid_q <= rpt_valid_d;
         rpt_long_q  <= rpt_long_d;
         rpt_ovr_q   <= rpt_ovr_d;
      end
   end

   // Next-state: sequence check, frame counting, report handshake, stall, clear
   always_comb begin
      state_d     = state_q;
      prev_vec_d  = vector;
      run_d       = run;
      mode_d      = mode;
      saw_long_d  = saw_long_q;
      frame_cnt_d = frame_cnt_q;
      long_cnt_d  = long_cnt_q;
      stall_cnt_d = stall_cnt_q;
      err_code_d  = err_code_q;
      err_seq_d   = err_seq_q;
      rpt_valid_d = rpt_valid_q;
      rpt_long_d  = rpt_long_q;
      rpt_ovr_d   = rpt_ovr_q;
      frame_done  = 1'b0;

      legal = (vector == 4'b0001) || (vector == 4'b0010) ||
              (vector == 4'b0100) || (vector == 4'b1000);

      // Sequencer output is one edge behind its inputs, so predict from last cycle
      exp_vec = prev_vec_q;
      if (run_q) begin
         case (prev_vec_q)
            4'b0001: exp_vec = 4'b0010;
            4'b0010: exp_vec = mode_q ? 4'b0100 : 4'b1000;
            4'b0100: exp_vec = 4'b1000;
            4'b1000: exp_vec = 4'b0001;
            default: exp_vec = prev_vec_q;
         endcase
      end

      if (!legal) begin
         err_code_d = 1'b1;
         state_d    = SYNC;
      end else if (state_q == SYNC) begin
         if (vector == 4'b0001) begin
            state_d    = TRACK;
            saw_long_d = 1'b0;
         end
      end else if (vector != exp_vec) begin
         err_seq_d = 1'b1;
         state_d   = SYNC;
      end else begin
         if (vector == 4'b0100) saw_long_d = 1'b1;
         frame_done = run_q && (prev_vec_q == 4'b1000) && (vector == 4'b0001);
      end

      if (frame_done) begin
         if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
         if (saw_long_q && (long_cnt_q != CNT_MAX)) long_cnt_d = long_cnt_q + CNT_WIDTH'(1);
         saw_long_d = 1'b0;
         if (!rpt_valid_q || rpt_ready) begin
            rpt_valid_d = 1'b1;
            rpt_long_d  = saw_long_q;
         end else begin
            rpt_ovr_d = 1'b1;
         end
      end else if (rpt_valid_q && rpt_ready) begin
         rpt_valid_d = 1'b0;
      end

      if (run)                            stall_cnt_d = '0;
      else if (stall_cnt_q != STALL_MAX)  stall_cnt_d = stall_cnt_q + SW'(1);

      // Clear wins over same-cycle increments and flag sets; report path untouched
      if (clr) begin
         frame_cnt_d = '0;
         long_cnt_d  = '0;
         err_code_d  = 1'b0;
         err_seq_d   = 1'b0;
         rpt_ovr_d   = 1'b0;
         stall_cnt_d = '0;
      end

      locked_d = (state_d == TRACK);
      stall_d  = (stall_cnt_d == STALL_MAX);
   end

   assign frame_count = frame_cnt_q;
   assign long_count  = long_cnt_q;
   assign locked      = locked_q;
   assign err_code    = err_code_q;
   assign err_seq     = err_seq_q;
   assign stall       = stall_q;
   assign rpt_valid   = rpt_valid_q;
   assign rpt_long    = rpt_long_q;
   assign rpt_overrun = rpt_ovr_q;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Directed bench for fsm_seq_monitor with a behavioural sequencer and report scoreboard.
module tb_fsm_seq_monitor;
   logic       clk = 1'b0;
   logic       rst_n, run, mode, clr, rpt_ready;
   logic [3:0] vector;
   logic [7:0] frame_count, long_count;
   logic       locked, err_code, err_seq, stall, rpt_valid, rpt_long, rpt_overrun;

   fsm_seq_monitor #(.CNT_WIDTH(8), .STALL_LIMIT(16)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .vector(vector), .clr(clr),
      .frame_count(frame_count), .long_count(long_count), .locked(locked),
      .err_code(err_code), .err_seq(err_seq), .stall(stall), .rpt_valid(rpt_valid),
      .rpt_ready(rpt_ready), .rpt_long(rpt_long), .rpt_overrun(rpt_overrun));

   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] seq = 4'b0001;
   logic       bsaw = 1'b0;
   logic       force_en = 1'b0;
   logic [3:0] force_val = 4'b0000;
   logic       cnt_en = 1'b1;
   logic       push_en = 1'b1;
   int         exp_frames = 0;
   int         exp_long = 0;
   logic       sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, consume a report if a handshake fires, advance the sequencer model
   task automatic step(input logic r, input logic m, input logic rdy, input logic c);
      logic e;
      run = r; mode = m; rpt_ready = rdy; clr = c;
      vector = force_en ? force_val : seq;
      if (rpt_valid && rpt_ready) begin
         if (sb_q.size() == 0) check("rpt_unexpected", 32'd1, 32'd0);
         else begin
            e = sb_q.pop_front();
            check("rpt_long", 32'(rpt_long), 32'(e));
         end
      end
      @(posedge clk); #1;
      if (c) begin exp_frames = 0; exp_long = 0; end
      if (r) begin
         case (seq)
            4'b0001: seq = 4'b0010;
            4'b0010: seq = m ? 4'b0100 : 4'b1000;
            4'b0100: seq = 4'b1000;
            default: begin
               if (cnt_en) begin exp_frames++; if (bsaw) exp_long++; end
               if (push_en) sb_q.push_back(bsaw);
               bsaw = 1'b0;
               seq  = 4'b0001;
            end
         endcase
         if (seq == 4'b0100) bsaw = 1'b1;
      end
   endtask

   task automatic frame(input logic m, input logic rdy);
      do step(1'b1, m, rdy, 1'b0); while (seq != 4'b0001);
   endtask

   task automatic flush(input logic rdy);
      step(1'b0, 1'b0, rdy, 1'b0);
      step(1'b0, 1'b0, rdy, 1'b0);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frames"}, 32'(frame_count), 32'(exp_frames));
      check({tag, "_long"}, 32'(long_count), 32'(exp_long));
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; mode = 1'b0; clr = 1'b0; rpt_ready = 1'b1;
      vector = 4'b0001;
      #3;
      check("rst_frames", 32'(frame_count), 32'd0);
      check("rst_long", 32'(long_count), 32'd0);
      check("rst_flags", {26'd0, locked, err_code, err_seq, stall, rpt_valid, rpt_overrun}, 32'd0);
      check("rst_rpt_long", 32'(rpt_long), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Three long frames with ready held high
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("lock_first", 32'(locked), 32'd1);
      repeat (3) frame(1'b1, 1'b1);
      flush(1'b1);
      check_counts("long3");
      check("long3_flags", {28'd0, err_code, err_seq, rpt_overrun, rpt_valid}, 32'd0);

      // Alternating short/long frames after a clear
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("clr_frames", 32'(frame_count), 32'd0);
      frame(1'b0, 1'b1); frame(1'b1, 1'b1); frame(1'b0, 1'b1); frame(1'b1, 1'b1);
      flush(1'b1);
      check_counts("alt4");

      // Wrong transition: 0010 -> 0100 while the short path was selected
      cnt_en = 1'b0; push_en = 1'b0;
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      force_en = 1'b1; force_val = 4'b0100;
      step(1'b1, 1'b0, 1'b1, 1'b0);
      force_en = 1'b0;
      check("seq_err_set", 32'(err_seq), 32'd1);
      check("seq_err_unlock", 32'(locked), 32'd0);
      check("seq_err_no_code", 32'(err_code), 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("seq_relock", 32'(locked), 32'd1);
      bsaw = 1'b0; cnt_en = 1'b1; push_en = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("seq_clr_err", 32'(err_seq), 32'd0);
      check("seq_clr_locked", 32'(locked), 32'd1);
      check_counts("seq_clr");
      frame(1'b0, 1'b1);
      flush(1'b1);
      check_counts("seq_after");

      // Illegal code for one cycle
      force_en = 1'b1; force_val = 4'b0011;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      force_en = 1'b0;
      check("code_err_set", 32'(err_code), 32'd1);
      check("code_err_unlock", 32'(locked), 32'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("code_relock", 32'(locked), 32'd1);
      frame(1'b1, 1'b1); frame(1'b0, 1'b1);
      flush(1'b1);
      check("code_err_sticky", 32'(err_code), 32'd1);
      check_counts("code_after");

      // Stall: run low for STALL_LIMIT cycles mid-frame
      step(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0);
         if (i == 15) check("stall_pre", 32'(stall), 32'd0);
      end
      check("stall_set", 32'(stall), 32'd1);
      check("stall_no_seq_err", 32'(err_seq), 32'd0);
      check("stall_locked", 32'(locked), 32'd1);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("stall_clear", 32'(stall), 32'd0);
      frame(1'b1, 1'b1);
      flush(1'b1);
      check_counts("stall_after");

      // Overrun: two completions with the consumer stalled
      step(1'b0, 1'b0, 1'b1, 1'b1);
      frame(1'b1, 1'b0);
      push_en = 1'b0;
      frame(1'b0, 1'b0);
      flush(1'b0);
      push_en = 1'b1;
      check("ovr_valid", 32'(rpt_valid), 32'd1);
      check("ovr_payload", 32'(rpt_long), 32'd1);
      check("ovr_flag", 32'(rpt_overrun), 32'd1);
      check("ovr_frames", 32'(frame_count), 32'd2);
      check("ovr_long", 32'(long_count), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("ovr_drained", 32'(rpt_valid), 32'd0);
      check("ovr_sb_empty", 32'(sb_q.size()), 32'd0);

      // Reset in the middle of a pending handshake
      frame(1'b1, 1'b0);
      flush(1'b0);
      check("rst_mid_pending", 32'(rpt_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(rpt_valid), 32'd0);
      check("rst_mid_locked", 32'(locked), 32'd0);
      check("rst_mid_frames", 32'(frame_count), 32'd0);
      sb_q.delete();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fsm_seq_monitor.md
Name: fsm_seq_monitor

Overview:
- Downstream consumer of the 4-state one-hot sequencer output (`vector`, 0001→0010→[0100]→1000→0001). It shares the sequencer's `run`/`mode` inputs.
- Each cycle it checks that `vector` follows the legal sequence given the previous cycle's `run`/`mode`.
- It counts completed frames (long = via 0100, short = skips 0100), flags errors and stalls, and emits one report per completed frame on a valid/ready handshake.

Parameters:
- CNT_WIDTH, 8, width of frame counters (saturating)
- STALL_LIMIT, 16, consecutive cycles with run=0 before `stall` asserts (≥1)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  same signal driving the sequencer
- mode  input  1  same signal driving the sequencer (1 = long path via 0100)
- vector  input  4  one-hot phase from the sequencer
- clr  input  1  synchronous clear of counters and sticky flags
- frame_count  output  CNT_WIDTH  total completed frames
- long_count  output  CNT_WIDTH  completed frames that passed 0100
- locked  output  1  monitor synchronised (state TRACK)
- err_code  output  1  sticky: vector not in {0001,0010,0100,1000} while locked or syncing
- err_seq  output  1  sticky: legal code but wrong transition
- stall  output  1  level: run low ≥ STALL_LIMIT consecutive cycles
- rpt_valid  output  1  frame report pending
- rpt_ready  input  1  consumer accepts report
- rpt_long  output  1  report payload: 1 = long frame
- rpt_overrun  output  1  sticky: frame completed while previous report still pending

Behaviour:
- Reset (async, rst_n=0): state SYNC; all counters 0; all flags 0; rpt_valid=0; rpt_long=0; internal registers prev_vec=0000, run_q=0, mode_q=0, saw_long=0, stall counter 0.
- Every edge: register prev_vec←vector, run_q←run, mode_q←mode. Checking uses vector (current) against prev_vec/run_q/mode_q (one edge old), matching the sequencer's registered-state, combinational-output timing.
- Expected next code from prev_vec when run_q=1: 0001→0010; 0010→0100 if mode_q else 1000; 0100→1000; 1000→0001. When run_q=0: expected = prev_vec.
- Illegal code (not one-hot of the four) in any state: set err_code and go to SYNC.
- State SYNC: locked=0, no sequence checks, no counting. Leave on first cycle vector==0001 → TRACK, clearing saw_long.
- State TRACK: locked=1.
  - vector≠expected (legal code): set err_seq, go to SYNC; no count that cycle.
  - vector==0100 entered: saw_long←1.
  - Transition 1000→0001 (run_q=1) completes a frame: frame_count++, long_count++ if saw_long; saw_long←0.
  - Report on frame completion:
    - If rpt_valid=0, or rpt_valid&rpt_ready on the same edge: load rpt_long←saw_long and rpt_valid←1.
    - Otherwise set rpt_overrun; held payload is unchanged and the new report is dropped.
- Counters saturate at 2^CNT_WIDTH−1; no wrap.
- Handshake: rpt_valid stays high and rpt_long stays stable until rpt_valid&rpt_ready at an edge. The report is then consumed and rpt_valid drops the next cycle unless a new frame completes on that edge (back-to-back allowed).
- Stall: counter increments while run=0, clears when run=1, saturates at STALL_LIMIT. stall = (counter==STALL_LIMIT). Stall does not change state.
- clr (sync):
  - Zeroes frame_count, long_count, err_code, err_seq, rpt_overrun, stall counter.
  - Does not change state, rpt_valid, or rpt_long.
  - If clr and a frame completion coincide, clr wins for counters (result 0); the report is still generated.
- rst_n asserted mid-frame or mid-handshake: immediate return to reset values; pending report lost.

Test Plan:
- Reset, run=1, mode=1, vector driven by the sequencer for 3 frames; rpt_ready=1 → locked after first 0001; frame_count=3, long_count=3; 3 rpt_valid pulses with rpt_long=1; no flags set.
- mode alternating 0/1 per frame, 4 frames → frame_count=4, long_count=2; rpt_long sequence matches the mode at the 0010 phase.
- While locked, force vector 0010→0100 with mode_q=0 → err_seq=1, locked=0 next cycle. Relock on next 0001; clr → err_seq=0, counters 0.
- Force vector=0011 for one cycle → err_code=1 sticky, locked=0. Subsequent frames count normally after resync.
- run=0 for 16 cycles mid-frame (vector held) → no err_seq; stall=1 on 16th cycle; stall=0 one cycle after run=1.
- rpt_ready=0 across 2 frame completions → first report held with rpt_long unchanged; rpt_overrun=1; frame_count=2. Assert rpt_ready → one transfer, rpt_valid=0 after.
